systolic_engine: RTL and testbench

Self-sequencing systolic matrix-multiply engine: accepts a streamed K-deep pair of operand vectors (ROWS-wide left, COLS-wide top) under valid/ready, applies input skew internally, runs the ROWS×COLS multiply-accumulate grid, drains it, and streams the ROWS×COLS result back one row per beat. It is the next generation of the buffered systolic module. It replaces external acc_rst/acc_en/shift_en/swap sequencing with an internal FSM and supports non-square arrays and variable K.

---
 rtl/systolic_engine_if.sv | 36 +++
 rtl/systolic_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_systolic_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_engine_if.sv
// systolic_engine_if: operand stream, result stream and job control of the
// systolic matrix-multiply engine. The engine binds to the slave modport;
// whoever feeds operands and drains results uses the master modport.
interface systolic_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int K_MAX      = 256
);
    localparam int K_W   = $clog2(K_MAX + 1);
    localparam int ROW_W = $clog2(ROWS);

    logic                       start;
    logic [K_W-1:0]             k_len;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_WIDTH*ROWS-1:0] in_left;
    logic [DATA_WIDTH*COLS-1:0] in_top;
    logic                       res_valid;
    logic                       res_ready;
    logic [OUT_WIDTH*COLS-1:0]  res_data;
    logic [ROW_W-1:0]           res_row;
    logic                       busy;
    logic                       done;

    modport master (
        output start, k_len, in_valid, in_left, in_top, res_ready,
        input  in_ready, res_valid, res_data, res_row, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, in_left, in_top, res_ready,
        output in_ready, res_valid, res_data, res_row, busy, done
    );
endinterface

// File: rtl/systolic_engine.sv
// systolic_engine: self-sequencing ROWS x COLS output-stationary systolic
// multiply-accumulate array. A job streams k_len operand beats (left column
// vector + top row vector), the array is drained with zeros for ROWS+COLS-1
// cycles, then the result matrix is returned one row per handshake.
// Optional feature macro: SYSTOLIC_OUT_SAT_EN -- when defined, accumulators
// are signed-saturated to OUT_WIDTH on readout; otherwise they are truncated.
module systolic_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int K_MAX      = 256
) (
    input  logic               clk,
    input  logic               rst,
    systolic_engine_if.slave   bus
);
    localparam int K_W     = $clog2(K_MAX + 1);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int DRAIN_W = $clog2(ROWS + COLS);
    localparam int PROD_W  = 2 * DATA_WIDTH;

`ifdef SYSTOLIC_OUT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_READOUT
    } state_t;

    state_t               state;
    logic [K_W-1:0]       k_lat;
    logic [K_W-1:0]       beat_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;

    // Accumulator to result-element conversion (saturate or wrap-truncate).
    function automatic logic [OUT_WIDTH-1:0] out_conv(input logic signed [ACC_WIDTH-1:0] v);
`ifdef SYSTOLIC_OUT_SAT_EN
        if (v > OUT_MAX)
            out_conv = OUT_WIDTH'(OUT_MAX);
        else if (v < OUT_MIN)
            out_conv = OUT_WIDTH'(OUT_MIN);
        else
            out_conv = OUT_WIDTH'(v);
`else
        out_conv = OUT_WIDTH'(v);
`endif
    endfunction

    // Array step enable: an accepted beat while streaming, or every drain cycle.
    logic feed_en;
    logic adv_p0;
    assign feed_en = (state == S_STREAM);
    assign adv_p0  = (bus.in_ready & bus.in_valid) | (state == S_DRAIN);

    // ---- stage p0: edge operands (zeros outside STREAM) and skew chains ----
    logic signed [DATA_WIDTH-1:0] left_in [ROWS];
    logic signed [DATA_WIDTH-1:0] top_in  [COLS];
    logic signed [DATA_WIDTH-1:0] left_skew_p0 [ROWS][ROWS];
    logic signed [DATA_WIDTH-1:0] top_skew_p0  [COLS][COLS];
    logic signed [DATA_WIDTH-1:0] a_edge [ROWS];
    logic signed [DATA_WIDTH-1:0] b_edge [COLS];

    // Unpack the operand vectors; inject zeros once streaming has finished.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            left_in[i] = '0;
            if (feed_en)
                left_in[i] = $signed(bus.in_left[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        for (int j = 0; j < COLS; j++) begin
            top_in[j] = '0;
            if (feed_en)
                top_in[j] = $signed(bus.in_top[j*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Row i enters the array after i skew stages, column j after j stages.
    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_left_edge
            if (gi == 0) begin : g_direct
                assign a_edge[gi] = left_in[gi];
            end else begin : g_skewed
                assign a_edge[gi] = left_skew_p0[gi][gi-1];
            end
        end
        for (gj = 0; gj < COLS; gj++) begin : g_top_edge
            if (gj == 0) begin : g_direct
                assign b_edge[gj] = top_in[gj];
            end else begin : g_skewed
                assign b_edge[gj] = top_skew_p0[gj][gj-1];
            end
        end
    endgenerate

    // ---- stage p1: PE operand registers, products and accumulators ----
    logic signed [DATA_WIDTH-1:0] a_p1 [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_p1 [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] a_in [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_in [ROWS][COLS];
    logic signed [PROD_W-1:0]     prod [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  acc  [ROWS][COLS];

    // Left operands flow rightwards, top operands flow downwards.
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_pe_row
            for (gj = 0; gj < COLS; gj++) begin : g_pe_col
                if (gj == 0) begin : g_a_edge
                    assign a_in[gi][gj] = a_edge[gi];
                end else begin : g_a_int
                    assign a_in[gi][gj] = a_p1[gi][gj-1];
                end
                if (gi == 0) begin : g_b_edge
                    assign b_in[gi][gj] = b_edge[gj];
                end else begin : g_b_int
                    assign b_in[gi][gj] = b_p1[gi-1][gj];
                end
                assign prod[gi][gj] = PROD_W'(a_in[gi][gj]) * PROD_W'(b_in[gi][gj]);
            end
        end
    endgenerate

    // Skew chains and PE operand registers: zeroed in CLEAR, shift on each step.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            for (int i = 0; i < ROWS; i++)
                for (int s = 0; s < ROWS; s++)
                    left_skew_p0[i][s] <= '0;
            for (int j = 0; j < COLS; j++)
                for (int s = 0; s < COLS; s++)
                    top_skew_p0[j][s] <= '0;
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_p1[i][j] <= '0;
                    b_p1[i][j] <= '0;
                end
        end else if (adv_p0) begin
            for (int i = 0; i < ROWS; i++) begin
                left_skew_p0[i][0] <= left_in[i];
                for (int s = 1; s < ROWS; s++)
                    left_skew_p0[i][s] <= left_skew_p0[i][s-1];
            end
            for (int j = 0; j < COLS; j++) begin
                top_skew_p0[j][0] <= top_in[j];
                for (int s = 1; s < COLS; s++)
                    top_skew_p0[j][s] <= top_skew_p0[j][s-1];
            end
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_p1[i][j] <= a_in[i][j];
                    b_p1[i][j] <= b_in[i][j];
                end
        end
    end

    // Accumulators: cleared on reset and in CLEAR, wrap-add the product on each step.
    always_ff @(posedge clk) begin
        if (rst || state == S_CLEAR) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc[i][j] <= '0;
        end else if (adv_p0) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc[i][j] <= acc[i][j] + ACC_WIDTH'(prod[i][j]);
        end
    end

    // ---- stage p2: converted result rows feeding the registered output ----
    logic [OUT_WIDTH*COLS-1:0] row_pack [ROWS];

    // Convert and pack each accumulator row into the res_data layout.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_pack[r] = '0;
            for (int j = 0; j < COLS; j++)
                row_pack[r][j*OUT_WIDTH +: OUT_WIDTH] = out_conv(acc[r][j]);
        end
    end

    // Job sequencer with registered handshake, status and result outputs.
    // The final drain step only pushes zeros through the far corner, so the
    // accumulators are already final when row 0 is captured on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            k_lat        <= '0;
            beat_cnt     <= '0;
            drain_cnt    <= '0;
            bus.in_ready <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data <= '0;
            bus.res_row  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        k_lat    <= (bus.k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : bus.k_len;
                        state    <= S_CLEAR;
                        bus.busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    beat_cnt  <= '0;
                    drain_cnt <= '0;
                    if (k_lat == '0) begin
                        state <= S_DRAIN;
                    end else begin
                        state        <= S_STREAM;
                        bus.in_ready <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (bus.in_valid) begin
                        beat_cnt <= beat_cnt + K_W'(1);
                        if (beat_cnt == k_lat - K_W'(1)) begin
                            state        <= S_DRAIN;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + DRAIN_W'(1);
                    if (drain_cnt == DRAIN_W'(ROWS + COLS - 2)) begin
                        state         <= S_READOUT;
                        bus.res_valid <= 1'b1;
                        bus.res_row   <= '0;
                        bus.res_data  <= row_pack[0];
                    end
                end
                S_READOUT: begin
                    if (bus.res_ready) begin
                        if (bus.res_row == ROW_W'(ROWS - 1)) begin
                            state         <= S_IDLE;
                            bus.res_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            bus.res_row  <= bus.res_row + ROW_W'(1);
                            bus.res_data <= row_pack[bus.res_row + ROW_W'(1)];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_engine.sv
// tb_systolic_engine: 4x4 engine, K_MAX=16, OUT_WIDTH=16. Stimulus is drawn
// with $urandom and results are compared against a sum-of-products matrix
// model that follows the output conversion selected by SYSTOLIC_OUT_SAT_EN.
module tb_systolic_engine;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int KM = 16;
    localparam int KW = $clog2(KM + 1);
    localparam int RW = $clog2(R);

    logic clk = 1'b0;
    logic rst = 1'b1;

    systolic_engine_if #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .OUT_WIDTH(OW), .K_MAX(KM)) bus();

    systolic_engine #(
        .DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .K_MAX(KM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int a_mem [32][R];
    int b_mem [32][C];
    logic [OW-1:0] exp_c [R][C];
    logic [OW-1:0] got   [R][C];

    int rows_got, order_err, stable_err, first_rv, done_cnt, done_busy_err;
    int seen_ready, busy_c1, ready_c2, timeout, beats;

    // Result element value of a mathematical dot product.
    function automatic logic [OW-1:0] to_out(input longint s);
        logic signed [AW-1:0] w;
        longint maxv, minv;
        w = s[AW-1:0];
        maxv = (64'sd1 <<< (OW - 1)) - 1;
        minv = -(64'sd1 <<< (OW - 1));
`ifdef SYSTOLIC_OUT_SAT_EN
        if (longint'(w) > maxv) return maxv[OW-1:0];
        if (longint'(w) < minv) return minv[OW-1:0];
        return w[OW-1:0];
`else
        return w[OW-1:0];
`endif
    endfunction

    // C = A^T-style product: C[r][j] = sum over beats of left[r] * top[j].
    task automatic model(input int k);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < C; j++) begin
                longint s = 0;
                for (int kk = 0; kk < k; kk++)
                    s += longint'(a_mem[kk][r]) * longint'(b_mem[kk][j]);
                exp_c[r][j] = to_out(s);
            end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < R; i++) a_mem[k][i] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < C; j++) b_mem[k][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < R; i++) a_mem[k][i] = av;
            for (int j = 0; j < C; j++) b_mem[k][j] = bv;
        end
    endtask

    // Runs one job; vmode: 0 valid high, 1 toggling, 2 random.
    // rmode: 0 ready high, 1 five-cycle stall on row 2, 2 random. noise: random start/k_len while busy.
    task automatic run_job(input int k_req, input int vmode, input int rmode, input bit noise);
        int c, exp_row, stall_left, post, prev_valid, prev_ready;
        logic [OW*C-1:0] prev_data;
        logic [RW-1:0] prev_row;
        bit fin, iv, rr;
        rows_got = 0; order_err = 0; stable_err = 0; first_rv = -1; done_cnt = 0;
        done_busy_err = 0; seen_ready = 0; busy_c1 = 0; ready_c2 = 0; timeout = 0; beats = 0;
        exp_row = 0; stall_left = 5; post = 0; prev_valid = 0; prev_ready = 1; fin = 0;
        prev_data = '0; prev_row = '0;
        bus.start = 1'b1; bus.k_len = KW'(k_req); bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c = 1;
        while (post < 4 && c < 3000) begin
            if (c == 1) busy_c1 = int'(bus.busy);
            if (c == 2) ready_c2 = int'(bus.in_ready);
            if (bus.in_ready) seen_ready++;
            if (bus.res_valid && first_rv < 0) first_rv = c;
            if (bus.res_valid && prev_valid != 0 && prev_ready == 0)
                if (bus.res_data !== prev_data || bus.res_row !== prev_row) stable_err++;
            if (bus.done) begin
                done_cnt++;
                if (bus.busy !== 1'b0) done_busy_err++;
                fin = 1;
            end
            if (fin) post++;
            case (vmode)
                0: iv = 1'b1;
                1: iv = c[0];
                default: iv = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = iv;
            for (int i = 0; i < R; i++)
                bus.in_left[i*DW +: DW] = (iv && beats < 32) ? a_mem[beats][i][DW-1:0] : DW'($urandom);
            for (int j = 0; j < C; j++)
                bus.in_top[j*DW +: DW] = (iv && beats < 32) ? b_mem[beats][j][DW-1:0] : DW'($urandom);
            case (rmode)
                0: rr = 1'b1;
                1: begin
                    rr = 1'b1;
                    if (bus.res_valid && bus.res_row == RW'(2) && stall_left > 0) begin
                        rr = 1'b0;
                        stall_left--;
                    end
                end
                default: rr = 1'($urandom_range(0, 1));
            endcase
            bus.res_ready = rr;
            bus.start = (noise && bus.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) bus.k_len = KW'($urandom);
            if (bus.in_ready && iv) beats++;
            if (bus.res_valid && rr) begin
                if (bus.res_row !== RW'(exp_row)) order_err++;
                if (exp_row < R) got[exp_row] = '{default: '0};
                for (int j = 0; j < C; j++)
                    if (exp_row < R) got[exp_row][j] = bus.res_data[j*OW +: OW];
                rows_got++;
                exp_row++;
            end
            prev_valid = int'(bus.res_valid); prev_ready = int'(rr);
            prev_data = bus.res_data; prev_row = bus.res_row;
            @(posedge clk); #1;
            c++;
        end
        if (c >= 3000) timeout = 1;
        bus.in_valid = 1'b0; bus.res_ready = 1'b0; bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", bus.res_valid); end
        total++; if (bus.res_data !== '0) begin bad++; $display("FAIL reset_res_data got=%h want=0", bus.res_data); end
        total++; if (bus.res_row !== '0) begin bad++; $display("FAIL reset_res_row got=%0d want=0", bus.res_row); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < R; i++) a_mem[k][i] = (i == k) ? 1 : 0;
            for (int j = 0; j < C; j++) b_mem[k][j] = 4 * k + j + 1;
        end
        run_job(4, 0, 0, 0);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < C; j++) begin
                total++;
                if (got[r][j] !== OW'(4 * r + j + 1)) begin
                    bad++; $display("FAIL identity_c[%0d][%0d] got=%0d want=%0d", r, j, got[r][j], 4 * r + j + 1);
                end
            end
        total++; if (first_rv != 13) begin bad++; $display("FAIL identity_latency got=%0d want=13", first_rv); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL identity_done_pulses got=%0d want=1", done_cnt); end
        total++; if (busy_c1 != 1) begin bad++; $display("FAIL identity_busy_t1 got=%0d want=1", busy_c1); end
        total++; if (ready_c2 != 1) begin bad++; $display("FAIL identity_in_ready_t2 got=%0d want=1", ready_c2); end
        total++; if (beats != 4) begin bad++; $display("FAIL identity_beats got=%0d want=4", beats); end
        total++; if (done_busy_err != 0) begin bad++; $display("FAIL identity_busy_at_done got=%0d want=0", done_busy_err); end
        total++; if (timeout != 0) begin bad++; $display("FAIL identity_timeout got=%0d want=0", timeout); end
    endtask

    task automatic test_k_zero();
        fill_random();
        run_job(0, 0, 0, 0);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < C; j++) begin
                total++;
                if (got[r][j] !== '0) begin bad++; $display("FAIL kzero_c[%0d][%0d] got=%0d want=0", r, j, got[r][j]); end
            end
        total++; if (seen_ready != 0) begin bad++; $display("FAIL kzero_in_ready_cycles got=%0d want=0", seen_ready); end
        total++; if (rows_got != R) begin bad++; $display("FAIL kzero_rows got=%0d want=%0d", rows_got, R); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL kzero_done_pulses got=%0d want=1", done_cnt); end
        total++; if (first_rv != 9) begin bad++; $display("FAIL kzero_latency got=%0d want=9", first_rv); end
    endtask

    task automatic test_stall_input();
        fill_const(3, 3);
        run_job(8, 1, 0, 0);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < C; j++) begin
                total++;
                if (got[r][j] !== OW'(72)) begin bad++; $display("FAIL stall_c[%0d][%0d] got=%0d want=72", r, j, got[r][j]); end
            end
        total++; if (beats != 8) begin bad++; $display("FAIL stall_beats got=%0d want=8", beats); end
        total++; if (timeout != 0) begin bad++; $display("FAIL stall_timeout got=%0d want=0", timeout); end
    endtask

    task automatic test_backpressure();
        fill_random();
        model(5);
        run_job(5, 0, 1, 0);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < C; j++) begin
                total++;
                if (got[r][j] !== exp_c[r][j]) begin
                    bad++; $display("FAIL bp_c[%0d][%0d] got=%0h want=%0h", r, j, got[r][j], exp_c[r][j]);
                end
            end
        total++; if (stable_err != 0) begin bad++; $display("FAIL bp_hold_stable got=%0d want=0", stable_err); end
        total++; if (order_err != 0) begin bad++; $display("FAIL bp_row_order got=%0d want=0", order_err); end
        total++; if (rows_got != R) begin bad++; $display("FAIL bp_rows got=%0d want=%0d", rows_got, R); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_saturation();
        fill_const(127, 127);
        for (int k = 0; k < 32; k++) a_mem[k][1] = -128;
        model(8);
        run_job(8, 0, 0, 0);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < C; j++) begin
                total++;
                if (got[r][j] !== exp_c[r][j]) begin
                    bad++; $display("FAIL sat_c[%0d][%0d] got=%0h want=%0h", r, j, got[r][j], exp_c[r][j]);
                end
            end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int k;
            k = int'($urandom_range(1, KM));
            fill_random();
            model(k);
            run_job(k, 2, 2, 1);
            for (int r = 0; r < R; r++)
                for (int j = 0; j < C; j++) begin
                    total++;
                    if (got[r][j] !== exp_c[r][j]) begin
                        bad++; $display("FAIL rand%0d_c[%0d][%0d] got=%0h want=%0h", n, r, j, got[r][j], exp_c[r][j]);
                    end
                end
            total++; if (beats != k) begin bad++; $display("FAIL rand%0d_beats got=%0d want=%0d", n, beats, k); end
            total++; if (done_cnt != 1) begin bad++; $display("FAIL rand%0d_done_pulses got=%0d want=1", n, done_cnt); end
            total++; if (stable_err != 0 || order_err != 0) begin
                bad++; $display("FAIL rand%0d_readout got=%0d/%0d want=0/0", n, stable_err, order_err);
            end
        end
    endtask

    task automatic test_clamp();
        fill_random();
        model(KM);
        run_job(31, 0, 0, 0);
        total++; if (beats != KM) begin bad++; $display("FAIL clamp_beats got=%0d want=%0d", beats, KM); end
        for (int r = 0; r < R; r++)
            for (int j = 0; j < C; j++) begin
                total++;
                if (got[r][j] !== exp_c[r][j]) begin
                    bad++; $display("FAIL clamp_c[%0d][%0d] got=%0h want=%0h", r, j, got[r][j], exp_c[r][j]);
                end
            end
    endtask

    task automatic test_reset_mid();
        int beat, guard, done_seen, busy_seen;
        fill_const(5, 7);
        beat = 0; guard = 0; done_seen = 0; busy_seen = 0;
        bus.start = 1'b1; bus.k_len = KW'(8);
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (beat < 3 && guard < 50) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < R; i++) bus.in_left[i*DW +: DW] = a_mem[beat][i][DW-1:0];
            for (int j = 0; j < C; j++) bus.in_top[j*DW +: DW] = b_mem[beat][j][DW-1:0];
            if (bus.in_ready) beat++;
            @(posedge clk); #1;
            guard++;
        end
        total++; if (beat != 3) begin bad++; $display("FAIL rstmid_beats got=%0d want=3", beat); end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready got=%b want=0", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        total++; if (bus.res_valid !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL rstmid_valid_done got=%b%b want=00", bus.res_valid, bus.done);
        end
        total++; if (bus.res_data !== '0 || bus.res_row !== '0) begin
            bad++; $display("FAIL rstmid_res got=%h/%0d want=0/0", bus.res_data, bus.res_row);
        end
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.done) done_seen++;
            if (bus.busy) busy_seen++;
            @(posedge clk); #1;
        end
        total++; if (done_seen != 0 || busy_seen != 0) begin
            bad++; $display("FAIL rstmid_idle got=done%0d/busy%0d want=0/0", done_seen, busy_seen);
        end
        fill_const(1, 1);
        run_job(2, 0, 0, 0);
        for (int r = 0; r < R; r++)
            for (int j = 0; j < C; j++) begin
                total++;
                if (got[r][j] !== OW'(2)) begin bad++; $display("FAIL rstmid_c[%0d][%0d] got=%0d want=2", r, j, got[r][j]); end
            end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL rstmid_done_pulses got=%0d want=1", done_cnt); end
    endtask

    initial begin
        bus.start = 1'b0; bus.k_len = '0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        bus.in_left = '0; bus.in_top = '0;
        test_reset();
        test_identity();
        test_k_zero();
        test_stall_input();
        test_backpressure();
        test_saturation();
        test_random();
        test_clamp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
